fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that lets N_REQ producers share the single write port of fifo_single_clock_reg_v2. It accepts words over a per-requester req/gnt handshake and drives the FIFO's w_req/w_data from registers. It tracks FIFO occupancy, including the in-flight write, so the FIFO never overflows. It halts on a FIFO fail indication until software clears the error.

---
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single-clock register FIFO; never overflows the FIFO
// and halts on a FIFO fail flag until clr_err. Build with ARB_STATS_EN for per-requester grant counters.
`ifdef ARB_STATS_EN
module arb_stat_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)                         cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
endmodule
`endif

module fifo_wr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr_err,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    fifo_w_req,
  output logic [DATA_W-1:0]       fifo_w_data,
  input  logic [CNT_W-1:0]        fifo_cnt,
  input  logic                    fifo_full,
  input  logic                    fifo_fail,
  output logic                    err,
  input  logic [PTR_W-1:0]        stat_sel,
  output logic [15:0]             stat_cnt
);
  typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, winner, winner_nxt;
  logic             found, space, issue;
  logic [CNT_W:0]   occ;

  // The registered write still in flight counts as occupied; FIFO reads are not credited.
  assign occ   = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, fifo_w_req};
  assign space = occ < (CNT_W+1)'(DEPTH);

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign winner_nxt = (winner == PTR_W'(N_REQ-1)) ? '0 : winner + PTR_W'(1);

  // A fail flag in the same cycle suppresses the grant so no word is lost on the way into ERR.
  assign issue = (state == RUN) && !rst && !fifo_fail && en && space && !fifo_full && found;
  assign gnt   = issue ? (N_REQ'(1) << winner) : '0;
  assign err   = (state == ERR);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (fifo_fail)             state_nxt = ERR;
      ERR:     if (clr_err && !fifo_fail) state_nxt = RUN;
      default:                            state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      rr_ptr      <= '0;
      fifo_w_req  <= 1'b0;
      fifo_w_data <= '0;
    end else begin
      state      <= state_nxt;
      fifo_w_req <= issue;
      if (issue) begin
        fifo_w_data <= data[int'(winner)*DATA_W +: DATA_W];
        rr_ptr      <= winner_nxt;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [N_REQ-1:0][15:0] stat_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    arb_stat_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (gnt[i]),
      .cnt (stat_q[i])
    );
  end

  assign stat_cnt = (int'(stat_sel) < N_REQ) ? stat_q[stat_sel] : 16'h0;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = 16'h0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for arbitration/FSM, plus FIFO fill, stats and reset sequences.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic          clk, rst, en, clr_err, fifo_w_req, fifo_full, fifo_fail, err;
  logic [N-1:0]  req, gnt;
  logic [N*W-1:0] data;
  logic [W-1:0]  fifo_w_data;
  logic [3:0]    fifo_cnt;
  logic [1:0]    stat_sel;
  logic [15:0]   stat_cnt;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .req(req), .data(data), .gnt(gnt),
    .fifo_w_req(fifo_w_req), .fifo_w_data(fifo_w_data), .fifo_cnt(fifo_cnt),
    .fifo_full(fifo_full), .fifo_fail(fifo_fail), .err(err),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic en, clr;
    logic [3:0] req, cnt;
    logic full, fail;
    logic [3:0] gnt;
    logic wreq;
    logic [31:0] wdata;
    logic err;
  } vec_t;

  vec_t tbl[23];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] dw(int i, int v);
    return {8'(8'hA0 + i), 24'(v)};
  endfunction

  function automatic vec_t mk(logic e, logic c, logic [3:0] r, logic [3:0] n, logic f, logic fl,
                              logic [3:0] g, logic wr, logic [31:0] wd, logic er);
    vec_t t;
    t.en = e; t.clr = c; t.req = r; t.cnt = n; t.full = f; t.fail = fl;
    t.gnt = g; t.wreq = wr; t.wdata = wd; t.err = er;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; req = 4'b1111; clr_err = 1'b0;
    fifo_cnt = '0; fifo_full = 1'b0; fifo_fail = 1'b0;
    #1 chk("rst_gnt", 32'(gnt), 32'h0);
    @(posedge clk); #1;
    chk("rst_wreq", 32'(fifo_w_req), 32'h0);
    chk("rst_wdata", fifo_w_data, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0; req = '0;
  endtask

  task automatic set_const_data();
    for (int i = 0; i < N; i++) data[i*W +: W] = 32'hF000_0000 + 32'(i);
  endtask

  initial begin
    logic [31:0] q[$];
    logic        pw;
    logic [31:0] pd;
    int          ng, ovf;

    rst = 1'b1; en = 1'b0; clr_err = 1'b0; req = '0; data = '0;
    fifo_cnt = '0; fifo_full = 1'b0; fifo_fail = 1'b0; stat_sel = '0;

    //        en clr req     cnt full fail | gnt     wreq wdata       err
    tbl[0]  = mk(1, 0, 4'b1111, 0, 0, 0, 4'b0001, 1, dw(0, 0),  0);
    tbl[1]  = mk(1, 0, 4'b1111, 0, 0, 0, 4'b0010, 1, dw(1, 1),  0);
    tbl[2]  = mk(1, 0, 4'b1111, 0, 0, 0, 4'b0100, 1, dw(2, 2),  0);
    tbl[3]  = mk(1, 0, 4'b1111, 0, 0, 0, 4'b1000, 1, dw(3, 3),  0);
    tbl[4]  = mk(1, 0, 4'b1111, 0, 0, 0, 4'b0001, 1, dw(0, 4),  0);
    tbl[5]  = mk(1, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, dw(0, 4),  0);
    tbl[6]  = mk(1, 0, 4'b0001, 0, 0, 0, 4'b0001, 1, dw(0, 6),  0);
    tbl[7]  = mk(1, 0, 4'b0001, 0, 0, 0, 4'b0001, 1, dw(0, 7),  0);
    tbl[8]  = mk(1, 0, 4'b0010, 7, 0, 0, 4'b0000, 0, dw(0, 7),  0);
    tbl[9]  = mk(1, 0, 4'b0010, 7, 0, 0, 4'b0010, 1, dw(1, 9),  0);
    tbl[10] = mk(1, 0, 4'b0010, 8, 1, 0, 4'b0000, 0, dw(1, 9),  0);
    tbl[11] = mk(1, 0, 4'b0100, 0, 1, 0, 4'b0000, 0, dw(1, 9),  0);
    tbl[12] = mk(0, 0, 4'b1010, 0, 0, 0, 4'b0000, 0, dw(1, 9),  0);
    tbl[13] = mk(0, 0, 4'b1010, 0, 0, 0, 4'b0000, 0, dw(1, 9),  0);
    tbl[14] = mk(1, 0, 4'b1010, 0, 0, 0, 4'b1000, 1, dw(3, 14), 0);
    tbl[15] = mk(1, 0, 4'b1010, 0, 0, 0, 4'b0010, 1, dw(1, 15), 0);
    tbl[16] = mk(1, 0, 4'b0010, 0, 0, 1, 4'b0000, 0, dw(1, 15), 1);
    tbl[17] = mk(1, 0, 4'b0010, 0, 0, 0, 4'b0000, 0, dw(1, 15), 1);
    tbl[18] = mk(1, 1, 4'b0010, 0, 0, 1, 4'b0000, 0, dw(1, 15), 1);
    tbl[19] = mk(1, 1, 4'b0010, 0, 0, 0, 4'b0000, 0, dw(1, 15), 0);
    tbl[20] = mk(1, 0, 4'b0010, 0, 0, 0, 4'b0010, 1, dw(1, 20), 0);
    tbl[21] = mk(1, 1, 4'b0100, 0, 0, 0, 4'b0100, 1, dw(2, 21), 0);
    tbl[22] = mk(1, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, dw(2, 21), 0);

    do_reset();

    for (int v = 0; v < 23; v++) begin
      @(negedge clk);
      en = tbl[v].en; clr_err = tbl[v].clr; req = tbl[v].req;
      fifo_cnt = tbl[v].cnt; fifo_full = tbl[v].full; fifo_fail = tbl[v].fail;
      for (int i = 0; i < N; i++) data[i*W +: W] = dw(i, v);
      #1 chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(tbl[v].gnt));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wreq", v), 32'(fifo_w_req), 32'(tbl[v].wreq));
      chk($sformatf("v%0d_wdata", v), fifo_w_data, tbl[v].wdata);
      chk($sformatf("v%0d_err", v), 32'(err), 32'(tbl[v].err));
    end
    @(negedge clk);
    clr_err = 1'b0; fifo_fail = 1'b0; fifo_full = 1'b0; fifo_cnt = '0; req = '0;

    // Fill a modelled 8-deep FIFO with no reads, then free one slot.
    do_reset();
    set_const_data();
    ng = 0; ovf = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 14) void'(q.pop_front());
      if (c == 14) begin
        chk("fill_grants", 32'(ng), 32'd8);
        chk("fill_level", 32'(q.size()), 32'd7);
        ng = 0;
      end
      @(negedge clk);
      req = 4'b1111; en = 1'b1;
      fifo_cnt = 4'(q.size()); fifo_full = (q.size() >= 8);
      pw = fifo_w_req; pd = fifo_w_data;
      #1 if (gnt != '0) ng++;
      @(posedge clk);
      if (pw) begin
        if (q.size() >= 8) ovf++;
        else q.push_back(pd);
      end
    end
    chk("refill_grants", 32'(ng), 32'd1);
    chk("fill_overflow", 32'(ovf), 32'd0);
    chk("refill_level", 32'(q.size()), 32'd8);
    for (int k = 0; k < 7; k++)
      chk($sformatf("fifo_word%0d", k), q[k], 32'hF000_0000 + 32'((k + 1) % 4));
    chk("fifo_word7", q[7], 32'hF000_0000);
    chk("fill_err", 32'(err), 32'd0);

    // 300 words from requester 2 only, FIFO kept drained.
    do_reset();
    set_const_data();
    ng = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      req = 4'b0100; fifo_cnt = '0; fifo_full = 1'b0;
      #1 if (gnt == 4'b0100) ng++;
    end
    chk("stat_grants", 32'(ng), 32'd300);
    @(negedge clk);
    req = '0; stat_sel = 2'd2;
    #1;
`ifdef ARB_STATS_EN
    chk("stat_sel2", 32'(stat_cnt), 32'd300);
`else
    chk("stat_sel2", 32'(stat_cnt), 32'd0);
`endif
    stat_sel = 2'd0;
    #1 chk("stat_sel0", 32'(stat_cnt), 32'd0);

    // Reset while a registered write is pending.
    @(negedge clk);
    req = 4'b0010;
    @(posedge clk); #1;
    chk("pre_rst_wreq", 32'(fifo_w_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rst_gnt", 32'(gnt), 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_wreq", 32'(fifo_w_req), 32'd0);
    chk("mid_rst_wdata", fifo_w_data, 32'h0);
    stat_sel = 2'd2;
    #1 chk("mid_rst_stat", 32'(stat_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
